// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the accumulator-CPU multi-cycle controller.
// Covers state encoding, opcode map and ALU function codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemRd,
    StExec,
    StMemWr
  } mc_state_e;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_NOT  = 3'b100;

  // ALU function for the EXEC phase of memory-operand instructions.
  function automatic logic [2:0] exec_alu_op(input logic [2:0] op);
    logic [2:0] fn;
    fn = ALU_PASS;
    unique case (op)
      OP_ADD:  fn = ALU_ADD;
      OP_SUB:  fn = ALU_SUB;
      OP_AND:  fn = ALU_AND;
      default: fn = ALU_PASS;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory strobe bundle. The step input exists only
// when MC_CTRL_STEP_EN is defined.
interface mc_controller_if #(
  parameter int unsigned CNT_W = 16
);
  logic [2:0]       opcode;
  logic             acc_zero;
  logic             mem_ready;
`ifdef MC_CTRL_STEP_EN
  logic             step;
`endif
  logic             pc_inc;
  logic             pc_ld;
  logic             adr_src;
  logic             mem_rd;
  logic             mem_wr;
  logic             ir_ld;
  logic             dr_ld;
  logic             acc_ld;
  logic [2:0]       alu_op;
  logic             retire;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
`ifdef MC_CTRL_STEP_EN
    input  step,
`endif
    input  opcode, acc_zero, mem_ready,
    output pc_inc, pc_ld, adr_src, mem_rd, mem_wr, ir_ld, dr_ld, acc_ld, alu_op, retire,
    output instr_cnt
  );

  modport slave (
`ifdef MC_CTRL_STEP_EN
    output step,
`endif
    output opcode, acc_zero, mem_ready,
    input  pc_inc, pc_ld, adr_src, mem_rd, mem_wr, ir_ld, dr_ld, acc_ld, alu_op, retire,
    input  instr_cnt
  );

endinterface

// File: rtl/mc_retire_counter.sv
// Wrapping count of retired instructions, cleared asynchronously by rst.
module mc_retire_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CntOne;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle fetch/decode/operand/execute sequencer for the accumulator CPU.
// MC_CTRL_STEP_EN adds single-step gating: park in IDLE after every instruction.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  mc_controller_if.master  bus
);

`ifdef MC_CTRL_STEP_EN
  localparam mc_state_e RetireNext = StIdle;
`else
  localparam mc_state_e RetireNext = StFetch;
`endif

  mc_state_e  state_q, state_d;
  logic       pc_inc, pc_ld, adr_src, mem_rd, mem_wr, ir_ld, dr_ld, acc_ld, retire;
  logic [2:0] alu_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    adr_src = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ir_ld   = 1'b0;
    dr_ld   = 1'b0;
    acc_ld  = 1'b0;
    alu_op  = ALU_PASS;
    retire  = 1'b0;

    unique case (state_q)
      StIdle: begin
`ifdef MC_CTRL_STEP_EN
        if (bus.step) state_d = StFetch;
`else
        state_d = StFetch;
`endif
      end
      StFetch: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        unique case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND: state_d = StMemRd;
          OP_STA: state_d = StMemWr;
          OP_JMP: begin
            pc_ld   = 1'b1;
            retire  = 1'b1;
            state_d = RetireNext;
          end
          OP_JZ: begin
            pc_ld   = bus.acc_zero;
            retire  = 1'b1;
            state_d = RetireNext;
          end
          OP_NOT: begin
            acc_ld  = 1'b1;
            alu_op  = ALU_NOT;
            retire  = 1'b1;
            state_d = RetireNext;
          end
        endcase
      end
      StMemRd: begin
        mem_rd  = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) begin
          dr_ld   = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        acc_ld  = 1'b1;
        alu_op  = exec_alu_op(bus.opcode);
        retire  = 1'b1;
        state_d = RetireNext;
      end
      StMemWr: begin
        mem_wr  = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = RetireNext;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.pc_inc  = pc_inc;
  assign bus.pc_ld   = pc_ld;
  assign bus.adr_src = adr_src;
  assign bus.mem_rd  = mem_rd;
  assign bus.mem_wr  = mem_wr;
  assign bus.ir_ld   = ir_ld;
  assign bus.dr_ld   = dr_ld;
  assign bus.acc_ld  = acc_ld;
  assign bus.alu_op  = alu_op;
  assign bus.retire  = retire;

  mc_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk (clk),
    .rst (rst),
    .en  (retire),
    .cnt (bus.instr_cnt)
  );

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control unit for the accumulator CPU. It sequences the 13-bit program counter, instruction register, data register, accumulator and a shared single-port memory through fetch, decode, operand and execute phases. Every memory access uses a ready handshake, so memory latency is variable. It sits beside the datapath and drives its load, increment and select strobes, and it counts retired instructions.

## Interface
- CNT_W, 16, width of the retired-instruction counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  3  IR[15:13], valid from DECODE onward
- acc_zero  in  1  accumulator == 0, from the datapath
- mem_ready  in  1  memory completes the current access this cycle
- step  in  1  single-step request (present only with MC_CTRL_STEP_EN)
- pc_inc  out  1  PC increment strobe
- pc_ld  out  1  PC load from IR[12:0]
- adr_src  out  1  memory address select: 0 = PC, 1 = IR[12:0]
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request (data = ACC)
- ir_ld  out  1  IR load from memory data
- dr_ld  out  1  DR load from memory data
- acc_ld  out  1  ACC load from ALU
- alu_op  out  3  000 pass DR, 001 ACC+DR, 010 ACC-DR, 011 ACC&DR, 100 ~ACC
- retire  out  1  one-cycle pulse when an instruction completes
- instr_cnt  out  CNT_W  retired-instruction count

## Operation
- Opcodes: 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 JMP, 101 JZ, 110 AND, 111 NOT.
- States: IDLE, FETCH, DECODE, MEM_RD, EXEC, MEM_WR.
- Unlisted outputs are 0 in every state. alu_op defaults to 000.
- IDLE: all strobes 0. Go to FETCH the next cycle.
- FETCH: mem_rd=1, adr_src=0.
  - When mem_ready=1: ir_ld=1 and pc_inc=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - LDA, ADD, SUB, AND: go to MEM_RD.
  - STA: go to MEM_WR.
  - JMP: pc_ld=1, retire=1, go to FETCH.
  - JZ: pc_ld=acc_zero, retire=1, go to FETCH.
  - NOT: acc_ld=1, alu_op=100, retire=1, go to FETCH.
- MEM_RD: mem_rd=1, adr_src=1. When mem_ready=1: dr_ld=1, go to EXEC.
- EXEC: acc_ld=1, alu_op = LDA 000, ADD 001, SUB 010, AND 011. Also retire=1, go to FETCH.
- MEM_WR: mem_wr=1, adr_src=1. When mem_ready=1: retire=1, go to FETCH.
- pc_inc and pc_ld are never asserted together.
- instr_cnt increments on every retire and wraps modulo 2^CNT_W.

## Timing
- Reset:
  - state=IDLE and instr_cnt=0, taking effect immediately.
  - All outputs are 0 while rst is high and during the IDLE cycle.
- State and instr_cnt are registered. Outputs are combinational from state, opcode, acc_zero and mem_ready (Mealy on mem_ready).
- Memory handshake:
  - mem_rd/mem_wr is held high until the cycle where mem_ready=1 is sampled, and is deasserted the next cycle.
  - mem_ready while no request is active is ignored.
- Latency with zero-wait memory (mem_ready tied 1):
  - JMP, JZ, NOT: 2 cycles.
  - STA: 3 cycles.
  - LDA, ADD, SUB, AND: 4 cycles.
- Each wait cycle adds 1.
- retire occurs on the final cycle of the instruction. instr_cnt shows the new value the following cycle.
- Reset asserted mid-instruction abandons the instruction. No retire, and instr_cnt is cleared.

## Configuration
- MC_CTRL_STEP_EN defined:
  - step port exists.
  - The FETCH→…→FETCH path instead returns to IDLE after retire.
  - IDLE leaves to FETCH only on a cycle with step=1, so each step pulse executes exactly one instruction.
  - step held high runs continuously, with one IDLE cycle per instruction.
- MC_CTRL_STEP_EN undefined: no step port. IDLE is visited only after reset.

## Structure
- mc_ctrl_pkg holds:
  - the state enum;
  - opcode constants (OP_LDA … OP_NOT);
  - ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT constants.
- One sub-module, mc_retire_counter: CNT_W-bit wrapping counter with async reset and an enable driven by retire.

## Test plan
- Reset, then ADD from PC=0, mem_ready tied 1:
  - mem_rd high in cycles 1 and 3 after IDLE;
  - ir_ld+pc_inc in cycle 1, dr_ld in cycle 3, acc_ld with alu_op=001 in cycle 4;
  - retire once, instr_cnt 0→1.
- STA with mem_ready low for 3 cycles:
  - mem_wr and adr_src=1 held for 4 cycles;
  - retire on the 4th cycle, next state FETCH.
- JZ:
  - acc_zero=1: pc_ld=1 in DECODE, pc_inc never with pc_ld.
  - acc_zero=0: pc_ld=0, retire still pulses.
- Reset asserted during MEM_RD: all outputs drop to 0 immediately, instr_cnt=0, FETCH resumes one cycle after release.
- instr_cnt preset path: 2^CNT_W NOT instructions → instr_cnt wraps to 0.
- With MC_CTRL_STEP_EN: two isolated step pulses → exactly two retire pulses, controller parked in IDLE between them.
